// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI receiver state encoding and line idle levels
package spi_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, DONE} rx_state_t;
  localparam logic SPI_CLK_IDLE = 1'b0;
  localparam logic SPI_SEL_IDLE = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rising/falling edge detect on the synced level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out,
  output logic rise_out,
  output logic fall_out
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d_in};
      prev <= sync[STAGES-1];
    end
  end
  assign q_out    = sync[STAGES-1];
  assign rise_out = q_out & ~prev;
  assign fall_out = ~q_out & prev;
endmodule

// File: rtl/spi_rx.sv
// spi_rx: oversampled SPI receiver recovering MSB-first words from sel/clk/data lines
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  error_out
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int HW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FULL  = CW'(DATA_WIDTH);
  localparam logic [HW-1:0] FLUSH = HW'(SYNC_STAGES);
  logic d_q, d_rise_unused, d_fall_unused;
  logic c_q_unused, c_rise, c_fall_unused;
  logic s_q, s_rise, s_fall;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [DATA_WIDTH-1:0] sr;
  logic overrun;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_data (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(data_in),
    .q_out(d_q), .rise_out(d_rise_unused), .fall_out(d_fall_unused)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CLK_IDLE)) u_clk (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(data_clk_in),
    .q_out(c_q_unused), .rise_out(c_rise), .fall_out(c_fall_unused)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_SEL_IDLE)) u_sel (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(sel_in),
    .q_out(s_q), .rise_out(s_rise), .fall_out(s_fall)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= WAIT_IDLE;
      cnt            <= '0;
      hold           <= '0;
      sr             <= '0;
      overrun        <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          hold <= s_q ? hold + 1'b1 : '0;
          if (s_q && hold == FLUSH) state <= IDLE;
        end
        IDLE: begin
          if (s_fall) begin
            cnt   <= '0;
            state <= RECV;
          end
        end
        RECV: begin
          if (cnt == FULL) begin
            data_out       <= sr;
            data_valid_out <= 1'b1;
            state          <= s_rise ? IDLE : DONE;
          end else if (s_rise) begin
            error_out <= cnt != '0;
            state     <= IDLE;
          end else if (c_rise) begin
            sr  <= {sr[DATA_WIDTH-2:0], d_q};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (s_rise || s_fall) begin
            error_out <= overrun;
            overrun   <= 1'b0;
            cnt       <= '0;
            state     <= s_fall ? RECV : IDLE;
          end else if (c_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: table-driven frame vectors plus reset/select corner sequences for spi_rx
module tb_spi_rx;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 6;
  typedef struct {
    logic [15:0] w;
    int          n;
    int          ev;
    int          ee;
    logic [7:0]  ed;
  } vec_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic data_in = 1'b0;
  logic data_clk_in = 1'b0;
  logic sel_in = 1'b1;
  logic [DW-1:0] data_out;
  logic data_valid_out, error_out;
  int cyc = 0;
  int vc = 0;
  int ec = 0;
  int last_v = -1;
  int rise_cyc = 0;
  int checks = 0;
  int passed = 0;
  logic both = 1'b0;
  vec_t tbl [8];
  spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .data_in(data_in),
    .data_clk_in(data_clk_in),
    .sel_in(sel_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .error_out(error_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (data_valid_out) begin
      vc++;
      last_v = cyc;
    end
    if (error_out) ec++;
    if (data_valid_out && error_out) both = 1'b1;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      data_in = w[15-i];
      tick(HALF);
      data_clk_in = 1'b1;
      if (i == DW - 1) rise_cyc = cyc;
      tick(HALF);
      data_clk_in = 1'b0;
    end
  endtask
  task automatic frame(input logic [15:0] w, input int n);
    sel_in = 1'b0;
    tick(HALF);
    send_bits(w, n);
    tick(HALF);
    sel_in = 1'b1;
    tick(12);
  endtask
  initial begin
    int v0, e0;
    tbl[0] = '{16'hA500, 8, 1, 0, 8'hA5};
    tbl[1] = '{16'h3C00, 8, 1, 0, 8'h3C};
    tbl[2] = '{16'hC300, 8, 1, 0, 8'hC3};
    tbl[3] = '{16'hB000, 5, 0, 1, 8'hC3};
    tbl[4] = '{16'h9600, 10, 1, 1, 8'h96};
    tbl[5] = '{16'h5A00, 8, 1, 0, 8'h5A};
    tbl[6] = '{16'hFF00, 8, 1, 0, 8'hFF};
    tbl[7] = '{16'h0000, 8, 1, 0, 8'h00};
    tick(3);
    check("reset data_out", int'(data_out), 0);
    check("reset valid", int'(data_valid_out), 0);
    check("reset error", int'(error_out), 0);
    rst_in = 1'b0;
    tick(10);
    for (int k = 0; k < 8; k++) begin
      v0 = vc;
      e0 = ec;
      frame(tbl[k].w, tbl[k].n);
      check($sformatf("vec%0d valid count", k), vc - v0, tbl[k].ev);
      check($sformatf("vec%0d error count", k), ec - e0, tbl[k].ee);
      check($sformatf("vec%0d data_out", k), int'(data_out), int'(tbl[k].ed));
      if (tbl[k].ev != 0) check($sformatf("vec%0d latency", k), last_v - rise_cyc, SS + 2);
    end
    v0 = vc;
    e0 = ec;
    sel_in = 1'b0;
    tick(HALF);
    send_bits(16'hA000, 3);
    rst_in = 1'b1;
    tick(2);
    rst_in = 1'b0;
    send_bits(16'hE800, 5);
    tick(HALF);
    sel_in = 1'b1;
    tick(12);
    check("midreset valid count", vc - v0, 0);
    check("midreset error count", ec - e0, 0);
    check("midreset data_out", int'(data_out), 0);
    v0 = vc;
    e0 = ec;
    frame(16'h5A00, 8);
    check("post-reset valid count", vc - v0, 1);
    check("post-reset error count", ec - e0, 0);
    check("post-reset data_out", int'(data_out), 8'h5A);
    v0 = vc;
    e0 = ec;
    sel_in = 1'b0;
    tick(HALF);
    sel_in = 1'b1;
    tick(HALF);
    repeat (3) begin
      data_in = 1'b1;
      data_clk_in = 1'b1;
      tick(HALF);
      data_clk_in = 1'b0;
      tick(HALF);
    end
    data_in = 1'b0;
    tick(12);
    check("idle toggle valid count", vc - v0, 0);
    check("idle toggle error count", ec - e0, 0);
    check("idle toggle data_out", int'(data_out), 8'h5A);
    check("valid/error overlap", int'(both), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
